// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO arbiter and its round-robin picker.
package pio_arb_pkg;

  localparam int unsigned PIO_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: lowest requesting index at or after ptr,
// wrapping modulo NREQ. Produces a one-hot grant, its index and a valid flag.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  int unsigned cand;

  // Scan forward from ptr; the first requester hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (32'(ptr) + off) % NREQ;
      if (!valid && req[cand[PTR_W-1:0]]) begin
        valid                  = 1'b1;
        idx                    = cand[PTR_W-1:0];
        grant[cand[PTR_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_arbiter.sv
// Round-robin arbiter that serialises single read/write requests from NREQ
// requesters onto one zero-wait Avalon-MM PIO slave. Every output is a flop.
module pio_arbiter
  import pio_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            we,
  input  logic [PIO_ADDR_W*NREQ-1:0] addr,
  input  logic [DATA_W*NREQ-1:0]     wdata,
  output logic [NREQ-1:0]            ack,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [PIO_ADDR_W-1:0]      pio_address,
  output logic                       pio_chipselect,
  output logic                       pio_write_n,
  output logic [31:0]                pio_writedata,
  input  logic [31:0]                pio_readdata
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  state_e                 state;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       win_idx;
  logic [NREQ-1:0]        win_grant;
  logic                   lat_we;

  logic [NREQ-1:0]        pick_grant;
  logic [PTR_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   sel_we;
  logic [PIO_ADDR_W-1:0]  sel_addr;
  logic [31:0]            sel_wdata;

  // Only the low DATA_W bits of readdata are consumed.
  logic                   unused_rd;
  assign unused_rd = ^pio_readdata;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Mux the winning requester's payload, zero-extending write data to 32 bits.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_we                 = we[i];
        sel_addr               = addr[PIO_ADDR_W*i +: PIO_ADDR_W];
        sel_wdata[DATA_W-1:0]  = wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // Transaction FSM; the PIO strobe flops double as the addr/wdata latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      win_idx        <= '0;
      win_grant      <= '0;
      lat_we         <= 1'b0;
      ack            <= '0;
      rdata          <= '0;
      busy           <= 1'b0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= '0;
      pio_writedata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state          <= ISSUE;
            win_idx        <= pick_idx;
            win_grant      <= pick_grant;
            lat_we         <= sel_we;
            busy           <= 1'b1;
            pio_chipselect <= 1'b1;
            pio_write_n    <= ~sel_we;
            pio_address    <= sel_addr;
            pio_writedata  <= sel_wdata;
          end
        end
        ISSUE: begin
          if (!lat_we) begin
            rdata <= pio_readdata[DATA_W-1:0];
          end
          ack            <= win_grant;
          state          <= ACK;
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          pio_address    <= '0;
          pio_writedata  <= '0;
        end
        ACK: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
          ptr   <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ack   <= '0;
        end
      endcase
    end
  end

endmodule
